// File: rtl/script_loader_mem.sv
// Script loader: snoops UART bytes for a header, captures a length-prefixed script into RAM
// and serves it on a registered pc-addressed port. Optional checksum byte: SCRIPT_LOADER_CSUM_EN.
module script_loader_mem #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned INST_BYTES = 2,
   parameter logic [1:0]  HDR_TAG    = 2'b10
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [7:0]              dataOut_bits,
   input  logic                    dataOut_valid,
   input  logic [ADDR_W-1:0]       pc,
   output logic [8*INST_BYTES-1:0] script,
   output logic                    script_mode,
   output logic                    script_ready,
   output logic [ADDR_W:0]         script_len,
   output logic                    load_err,
   output logic                    csum_err
);

   localparam int unsigned INST_W = 8 * INST_BYTES;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned BCNT_W = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(INST_BYTES - 1);
   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_LOAD
`ifdef SCRIPT_LOADER_CSUM_EN
      , S_CSUM
`endif
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   state_t                w_done_state;

   logic [15:0]           r_n;
   logic [15:0]           r_inst_cnt;
   logic [BCNT_W-1:0]     r_byte_cnt;
   logic [INST_W-1:0]     r_word;
   logic                  r_mode;
   logic                  r_ready;
   logic [ADDR_W:0]       r_len;
   logic                  r_load_err;
   logic [INST_W-1:0]     r_script;
   logic [INST_W-1:0]     r_mem [DEPTH];

   logic [15:0]           w_n_nxt;
   logic [15:0]           w_inst_cnt_nxt;
   logic [BCNT_W-1:0]     w_byte_cnt_nxt;
   logic [INST_W-1:0]     w_word_nxt;
   logic                  w_ready_nxt;
   logic [ADDR_W:0]       w_len_nxt;
   logic                  w_load_err_nxt;
   logic                  w_we;
   logic [ADDR_W-1:0]     w_waddr;
   logic [15:0]           w_n_full;
   logic [15:0]           w_inst_inc;
   logic [INST_W-1:0]     w_word_in;
   logic [ADDR_W:0]       w_len_clamp;
   logic                  w_is_hdr;
   logic                  w_rd_ok;

`ifdef SCRIPT_LOADER_CSUM_EN
   logic [7:0]            r_csum;
   logic                  r_csum_err;
   logic [7:0]            w_csum_nxt;
   logic                  w_csum_err_nxt;
   assign w_done_state = S_CSUM;
`else
   assign w_done_state = S_IDLE;
`endif

   assign w_n_full    = {dataOut_bits, r_n[7:0]};
   assign w_inst_inc  = r_inst_cnt + 16'd1;
   // Width cast keeps the low INST_W bits: shifts the word left by one byte, new byte at the bottom.
   assign w_word_in   = INST_W'({r_word, dataOut_bits});
   assign w_len_clamp = (32'(r_n) > DEPTH) ? DEPTH_L : (ADDR_W + 1)'(r_n);
   assign w_is_hdr    = dataOut_valid && (dataOut_bits[1:0] == HDR_TAG);
   assign w_waddr     = ADDR_W'(r_inst_cnt);
   assign w_rd_ok     = r_ready && ((ADDR_W + 1)'(pc) < r_len);

   always_comb begin
      w_state_nxt    = r_state;
      w_n_nxt        = r_n;
      w_inst_cnt_nxt = r_inst_cnt;
      w_byte_cnt_nxt = r_byte_cnt;
      w_word_nxt     = r_word;
      w_ready_nxt    = r_ready;
      w_len_nxt      = r_len;
      w_load_err_nxt = r_load_err;
      w_we           = 1'b0;
`ifdef SCRIPT_LOADER_CSUM_EN
      w_csum_nxt     = r_csum;
      w_csum_err_nxt = r_csum_err;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_is_hdr) begin
               w_state_nxt    = S_LEN_LO;
               w_ready_nxt    = 1'b0;
               w_load_err_nxt = 1'b0;
`ifdef SCRIPT_LOADER_CSUM_EN
               w_csum_nxt     = 8'h00;
               w_csum_err_nxt = 1'b0;
`endif
            end
         end
         S_LEN_LO: begin
            if (dataOut_valid) begin
               w_n_nxt     = {r_n[15:8], dataOut_bits};
               w_state_nxt = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (dataOut_valid) begin
               w_n_nxt        = w_n_full;
               w_load_err_nxt = (32'(w_n_full) > DEPTH);
               w_inst_cnt_nxt = '0;
               w_byte_cnt_nxt = '0;
               if (w_n_full == 16'd0) begin
                  w_len_nxt   = '0;
                  w_state_nxt = w_done_state;
`ifndef SCRIPT_LOADER_CSUM_EN
                  w_ready_nxt = 1'b1;
`endif
               end else begin
                  w_state_nxt = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (dataOut_valid) begin
               w_word_nxt = w_word_in;
`ifdef SCRIPT_LOADER_CSUM_EN
               w_csum_nxt = r_csum ^ dataOut_bits;
`endif
               if (r_byte_cnt == LAST_BYTE) begin
                  w_byte_cnt_nxt = '0;
                  w_inst_cnt_nxt = w_inst_inc;
                  // Instructions beyond DEPTH are consumed but never written, so no wrap onto addr 0.
                  w_we           = (32'(r_inst_cnt) < DEPTH);
                  if (w_inst_inc == r_n) begin
                     w_len_nxt   = w_len_clamp;
                     w_state_nxt = w_done_state;
`ifndef SCRIPT_LOADER_CSUM_EN
                     w_ready_nxt = 1'b1;
`endif
                  end
               end else begin
                  w_byte_cnt_nxt = r_byte_cnt + BCNT_W'(1);
               end
            end
         end
`ifdef SCRIPT_LOADER_CSUM_EN
         S_CSUM: begin
            if (dataOut_valid) begin
               w_state_nxt = S_IDLE;
               if (dataOut_bits == r_csum) begin
                  w_ready_nxt = 1'b1;
               end else begin
                  w_ready_nxt    = 1'b0;
                  w_csum_err_nxt = 1'b1;
                  w_len_nxt      = '0;
               end
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_n        <= '0;
         r_inst_cnt <= '0;
         r_byte_cnt <= '0;
         r_word     <= '0;
         r_mode     <= 1'b0;
         r_ready    <= 1'b0;
         r_len      <= '0;
         r_load_err <= 1'b0;
         r_script   <= '0;
      end else begin
         r_n        <= w_n_nxt;
         r_inst_cnt <= w_inst_cnt_nxt;
         r_byte_cnt <= w_byte_cnt_nxt;
         r_word     <= w_word_nxt;
         r_mode     <= (w_state_nxt != S_IDLE);
         r_ready    <= w_ready_nxt;
         r_len      <= w_len_nxt;
         r_load_err <= w_load_err_nxt;
         r_script   <= w_rd_ok ? r_mem[pc] : '0;
      end
   end

`ifdef SCRIPT_LOADER_CSUM_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_csum     <= 8'h00;
         r_csum_err <= 1'b0;
      end else begin
         r_csum     <= w_csum_nxt;
         r_csum_err <= w_csum_err_nxt;
      end
   end
   assign csum_err = r_csum_err;
`else
   assign csum_err = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_word_in;
      end
   end

   assign script       = r_script;
   assign script_mode  = r_mode;
   assign script_ready = r_ready;
   assign script_len   = r_len;
   assign load_err     = r_load_err;

endmodule

// File: tb/tb_script_loader_mem.sv
// Directed self-checking bench for script_loader_mem; a second instance with ADDR_W=2 covers overflow.
module tb_script_loader_mem;

   logic        clock;
   logic        reset;
   logic        valid;
   logic [7:0]  bits;
   logic [7:0]  pc;

   logic [15:0] script_b;
   logic        mode_b, ready_b, lerr_b, cerr_b;
   logic [8:0]  len_b;
   logic [15:0] script_s;
   logic        mode_s, ready_s, lerr_s, cerr_s;
   logic [2:0]  len_s;

   int          n_checks;
   int          n_errors;
   logic [7:0]  tb_x;

   script_loader_mem #(.ADDR_W(8), .INST_BYTES(2), .HDR_TAG(2'b10)) dut (
      .clock(clock), .reset(reset), .dataOut_bits(bits), .dataOut_valid(valid),
      .pc(pc), .script(script_b), .script_mode(mode_b), .script_ready(ready_b),
      .script_len(len_b), .load_err(lerr_b), .csum_err(cerr_b)
   );

   script_loader_mem #(.ADDR_W(2), .INST_BYTES(2), .HDR_TAG(2'b10)) dut_s (
      .clock(clock), .reset(reset), .dataOut_bits(bits), .dataOut_valid(valid),
      .pc(pc[1:0]), .script(script_s), .script_mode(mode_s), .script_ready(ready_s),
      .script_len(len_s), .load_err(lerr_s), .csum_err(cerr_s)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic send_byte(input logic [7:0] b);
      bits  = b;
      valid = 1'b1;
      @(negedge clock);
      valid = 1'b0;
      bits  = 8'h00;
   endtask

   task automatic send_hdr(input logic [7:0] b);
      tb_x = 8'h00;
      send_byte(b);
   endtask

   task automatic send_data(input logic [7:0] b);
      tb_x = tb_x ^ b;
      send_byte(b);
   endtask

   task automatic send_trailer();
`ifdef SCRIPT_LOADER_CSUM_EN
      send_byte(tb_x);
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({script_b, mode_b, ready_b, len_b, lerr_b, cerr_b} !== 30'd0) begin
         n_errors++; $display("FAIL reset_big: got %h expected 0", {script_b, mode_b, ready_b, len_b, lerr_b, cerr_b});
      end
      n_checks++;
      if ({script_s, mode_s, ready_s, len_s, lerr_s, cerr_s} !== 24'd0) begin
         n_errors++; $display("FAIL reset_small: got %h expected 0", {script_s, mode_s, ready_s, len_s, lerr_s, cerr_s});
      end
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      n_checks++;
      if ({script_b, mode_b, ready_b, len_b, lerr_b, cerr_b} !== 30'd0) begin
         n_errors++; $display("FAIL post_reset: got %h expected 0", {script_b, mode_b, ready_b, len_b, lerr_b, cerr_b});
      end
   endtask

   task automatic test_basic();
      logic [7:0]  pcs [4];
      logic [15:0] exp [4];
      pcs = '{8'd0, 8'd1, 8'd2, 8'd255};
      exp = '{16'h1234, 16'hABCD, 16'h0000, 16'h0000};
      send_hdr(8'h02);
      n_checks++;
      if (mode_b !== 1'b1) begin n_errors++; $display("FAIL basic_mode_hdr: got %b expected 1", mode_b); end
      send_byte(8'h02);
      send_byte(8'h00);
      send_data(8'h12);
      send_data(8'h34);
      send_data(8'hAB);
      n_checks++;
      if (mode_b !== 1'b1 || ready_b !== 1'b0) begin
         n_errors++; $display("FAIL basic_mid_load: got mode=%b ready=%b expected mode=1 ready=0", mode_b, ready_b);
      end
      send_data(8'hCD);
`ifdef SCRIPT_LOADER_CSUM_EN
      n_checks++;
      if (mode_b !== 1'b1) begin n_errors++; $display("FAIL basic_mode_csum: got %b expected 1", mode_b); end
      send_trailer();
`endif
      n_checks++;
      if (mode_b !== 1'b0) begin n_errors++; $display("FAIL basic_mode_end: got %b expected 0", mode_b); end
      n_checks++;
      if (ready_b !== 1'b1) begin n_errors++; $display("FAIL basic_ready: got %b expected 1", ready_b); end
      n_checks++;
      if (len_b !== 9'd2) begin n_errors++; $display("FAIL basic_len: got %0d expected 2", len_b); end
      n_checks++;
      if (lerr_b !== 1'b0 || cerr_b !== 1'b0) begin
         n_errors++; $display("FAIL basic_errs: got load_err=%b csum_err=%b expected 0 0", lerr_b, cerr_b);
      end
      for (int i = 0; i < 4; i++) begin
         pc = pcs[i];
         @(negedge clock);
         n_checks++;
         if (script_b !== exp[i]) begin
            n_errors++; $display("FAIL basic_read pc=%0d: got %h expected %h", pcs[i], script_b, exp[i]);
         end
      end
   endtask

   task automatic test_reload();
      logic [15:0] exp [3];
      exp = '{16'hBEEF, 16'h0000, 16'h0000};
      pc = 8'd0;
      send_hdr(8'h02);
      n_checks++;
      if (ready_b !== 1'b0) begin n_errors++; $display("FAIL reload_ready_drop: got %b expected 0", ready_b); end
      send_byte(8'h01);
      send_byte(8'h00);
      send_data(8'hBE);
      n_checks++;
      if (script_b !== 16'h0000) begin n_errors++; $display("FAIL reload_script_during_load: got %h expected 0000", script_b); end
      send_data(8'hEF);
      send_trailer();
      n_checks++;
      if (ready_b !== 1'b1 || len_b !== 9'd1) begin
         n_errors++; $display("FAIL reload_status: got ready=%b len=%0d expected 1 1", ready_b, len_b);
      end
      for (int i = 0; i < 3; i++) begin
         pc = 8'(i);
         @(negedge clock);
         n_checks++;
         if (script_b !== exp[i]) begin
            n_errors++; $display("FAIL reload_read pc=%0d: got %h expected %h", i, script_b, exp[i]);
         end
      end
   endtask

   task automatic test_zero_len();
      send_byte(8'h01);
      n_checks++;
      if (mode_b !== 1'b0 || ready_b !== 1'b1) begin
         n_errors++; $display("FAIL zero_nonhdr: got mode=%b ready=%b expected 0 1", mode_b, ready_b);
      end
      send_hdr(8'h06);
      n_checks++;
      if (mode_b !== 1'b1) begin n_errors++; $display("FAIL zero_mode_hdr: got %b expected 1", mode_b); end
      send_byte(8'h00);
      send_byte(8'h00);
      send_trailer();
      n_checks++;
      if (ready_b !== 1'b1 || len_b !== 9'd0 || mode_b !== 1'b0) begin
         n_errors++; $display("FAIL zero_status: got ready=%b len=%0d mode=%b expected 1 0 0", ready_b, len_b, mode_b);
      end
      for (int i = 0; i < 2; i++) begin
         pc = 8'(i);
         @(negedge clock);
         n_checks++;
         if (script_b !== 16'h0000) begin
            n_errors++; $display("FAIL zero_read pc=%0d: got %h expected 0000", i, script_b);
         end
      end
   endtask

   task automatic test_overflow();
      send_hdr(8'hFE);
      send_byte(8'h05);
      send_byte(8'h00);
      n_checks++;
      if (lerr_s !== 1'b1 || lerr_b !== 1'b0) begin
         n_errors++; $display("FAIL ovf_load_err: got small=%b big=%b expected 1 0", lerr_s, lerr_b);
      end
      for (int i = 0; i < 9; i++) send_data(8'h10 + 8'(i));
      n_checks++;
      if (mode_s !== 1'b1) begin n_errors++; $display("FAIL ovf_mode_mid: got %b expected 1", mode_s); end
      send_data(8'h19);
      send_trailer();
      n_checks++;
      if (mode_s !== 1'b0 || ready_s !== 1'b1) begin
         n_errors++; $display("FAIL ovf_end: got mode=%b ready=%b expected 0 1", mode_s, ready_s);
      end
      n_checks++;
      if (len_s !== 3'd4 || lerr_s !== 1'b1) begin
         n_errors++; $display("FAIL ovf_len: got len=%0d load_err=%b expected 4 1", len_s, lerr_s);
      end
      n_checks++;
      if (len_b !== 9'd5) begin n_errors++; $display("FAIL ovf_big_len: got %0d expected 5", len_b); end
      pc = 8'd0;
      @(negedge clock);
      n_checks++;
      if (script_s !== 16'h1011) begin n_errors++; $display("FAIL ovf_read0: got %h expected 1011", script_s); end
      pc = 8'd3;
      @(negedge clock);
      n_checks++;
      if (script_s !== 16'h1617) begin n_errors++; $display("FAIL ovf_read3: got %h expected 1617", script_s); end
      pc = 8'd4;
      @(negedge clock);
      n_checks++;
      if (script_b !== 16'h1819) begin n_errors++; $display("FAIL ovf_big_read4: got %h expected 1819", script_b); end
   endtask

   task automatic test_exact_depth();
      send_hdr(8'h02);
      send_byte(8'h04);
      send_byte(8'h00);
      n_checks++;
      if (lerr_s !== 1'b0) begin n_errors++; $display("FAIL exact_load_err: got %b expected 0", lerr_s); end
      for (int i = 0; i < 8; i++) send_data(8'hA0 + 8'(i));
      send_trailer();
      n_checks++;
      if (len_s !== 3'd4 || ready_s !== 1'b1 || lerr_s !== 1'b0) begin
         n_errors++; $display("FAIL exact_status: got len=%0d ready=%b load_err=%b expected 4 1 0", len_s, ready_s, lerr_s);
      end
      pc = 8'd3;
      @(negedge clock);
      n_checks++;
      if (script_s !== 16'hA6A7) begin n_errors++; $display("FAIL exact_read3: got %h expected a6a7", script_s); end
   endtask

   task automatic test_reset_midload();
      pc = 8'd0;
      send_hdr(8'h02);
      send_byte(8'h02);
      send_byte(8'h00);
      send_data(8'h11);
      send_data(8'h22);
      send_data(8'h33);
      reset = 1'b1;
      #1;
      n_checks++;
      if ({script_b, mode_b, ready_b, len_b, lerr_b, cerr_b} !== 30'd0) begin
         n_errors++; $display("FAIL midload_reset: got %h expected 0", {script_b, mode_b, ready_b, len_b, lerr_b, cerr_b});
      end
      @(negedge clock);
      reset = 1'b0;
      send_hdr(8'h02);
      send_byte(8'h01);
      send_byte(8'h00);
      send_data(8'h55);
      send_data(8'h66);
      send_trailer();
      n_checks++;
      if (ready_b !== 1'b1 || len_b !== 9'd1) begin
         n_errors++; $display("FAIL midload_reload_status: got ready=%b len=%0d expected 1 1", ready_b, len_b);
      end
      pc = 8'd0;
      @(negedge clock);
      n_checks++;
      if (script_b !== 16'h5566) begin n_errors++; $display("FAIL midload_read0: got %h expected 5566", script_b); end
      pc = 8'd1;
      @(negedge clock);
      n_checks++;
      if (script_b !== 16'h0000) begin n_errors++; $display("FAIL midload_read1: got %h expected 0000", script_b); end
   endtask

`ifdef SCRIPT_LOADER_CSUM_EN
   task automatic test_csum();
      pc = 8'd0;
      send_hdr(8'h02);
      send_byte(8'h01);
      send_byte(8'h00);
      send_data(8'h12);
      send_data(8'h34);
      send_byte(8'h26);
      n_checks++;
      if (ready_b !== 1'b1 || cerr_b !== 1'b0) begin
         n_errors++; $display("FAIL csum_good: got ready=%b csum_err=%b expected 1 0", ready_b, cerr_b);
      end
      @(negedge clock);
      n_checks++;
      if (script_b !== 16'h1234) begin n_errors++; $display("FAIL csum_good_read: got %h expected 1234", script_b); end
      send_hdr(8'h02);
      send_byte(8'h01);
      send_byte(8'h00);
      send_data(8'h12);
      send_data(8'h34);
      send_byte(8'h27);
      n_checks++;
      if (cerr_b !== 1'b1 || ready_b !== 1'b0 || len_b !== 9'd0) begin
         n_errors++; $display("FAIL csum_bad: got csum_err=%b ready=%b len=%0d expected 1 0 0", cerr_b, ready_b, len_b);
      end
      @(negedge clock);
      n_checks++;
      if (script_b !== 16'h0000) begin n_errors++; $display("FAIL csum_bad_read: got %h expected 0000", script_b); end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_errors = 0;
      tb_x     = 8'h00;
      reset    = 1'b1;
      valid    = 1'b0;
      bits     = 8'h00;
      pc       = 8'd0;
      @(negedge clock);
      test_reset();
      test_basic();
      test_reload();
      test_zero_len();
      test_overflow();
      test_exact_depth();
      test_reset_midload();
`ifdef SCRIPT_LOADER_CSUM_EN
      test_csum();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
